// File: rtl/ecg_axis_pkg.sv
// Shared types and default widths for the ECG sample stream blocks.
package ecg_axis_pkg;

  localparam int unsigned INOUT_WIDTH_DEF     = 16;
  localparam int unsigned ADC_WIDTH_DEF       = 12;
  localparam int unsigned FIFO_ADDR_WIDTH_DEF = 3;
  localparam int unsigned TICK_DIV_500HZ      = 200000;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/ecg_sync_fifo.sv
// First-word-fall-through synchronous FIFO; dout holds the head entry, or the
// last popped entry once empty. A push while full only lands with a same-cycle pop.
module ecg_sync_fifo #(
  parameter int unsigned width      = 16,
  parameter int unsigned addr_width = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [width-1:0]      din,
  input  logic                  pop,
  output logic [width-1:0]      dout,
  output logic                  empty,
  output logic                  full,
  output logic [addr_width:0]   level
);

  localparam int unsigned DEPTH = 1 << addr_width;
  localparam int unsigned AW    = addr_width;
  localparam int unsigned LW    = addr_width + 1;

  logic [width-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop_ok_c;
  logic             push_ok_c;
  logic [LW-1:0]    level_next_c;

  assign pop_ok_c  = pop && !empty;
  assign push_ok_c = push && (!full || pop_ok_c);

  always_comb begin
    level_next_c = level;
    if (push_ok_c && !pop_ok_c) begin
      level_next_c = level + LW'(1);
    end else if (!push_ok_c && pop_ok_c) begin
      level_next_c = level - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_c) begin
      mem[wr_ptr] <= din;
    end
  end

  // Head register: load the incoming word when it becomes the head, else the next stored entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      dout   <= '0;
    end else begin
      if (push_ok_c) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok_c) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      level <= level_next_c;
      empty <= (level_next_c == LW'(0));
      full  <= (level_next_c == LW'(DEPTH));
      if (push_ok_c && (empty || (pop_ok_c && level == LW'(1)))) begin
        dout <= din;
      end else if (pop_ok_c && level > LW'(1)) begin
        dout <= mem[rd_ptr + AW'(1)];
      end
    end
  end

endmodule

// File: rtl/ecg_axis_sample_source.sv
// Fixed-rate ADC sampler feeding an AXI4-Stream master through a FWFT FIFO.
// Define ADC_OFFSET_BINARY_EN when the ADC delivers offset-binary codes.
module ecg_axis_sample_source
  import ecg_axis_pkg::*;
#(
  parameter int unsigned inout_width     = INOUT_WIDTH_DEF,
  parameter int unsigned adc_width       = ADC_WIDTH_DEF,
  parameter int unsigned tick_div        = TICK_DIV_500HZ,
  parameter int unsigned fifo_addr_width = FIFO_ADDR_WIDTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  output logic                       sample_req,
  input  logic                       adc_valid,
  input  logic [adc_width-1:0]       adc_data,
  output logic [inout_width-1:0]     m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [fifo_addr_width:0]   fifo_level,
  output logic                       overflow,
  output logic                       missed,
  input  logic                       clear_flags
);

  localparam int unsigned CW    = $clog2(tick_div);
  localparam int unsigned SHIFT = inout_width - adc_width;

  logic [CW-1:0]          count;
  logic                   tick_c;
  state_t                 state;
  state_t                 state_next_c;
  logic                   req_c;
  logic                   push_c;
  logic                   miss_c;
  logic                   pop_c;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic [adc_width-1:0]   code_c;
  logic [inout_width-1:0] aligned_c;

  // Sample-rate divider, held at zero while disabled.
  assign tick_c = enable && (count == CW'(tick_div - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!enable || tick_c) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next_c;
    end
  end

  // A tick in WAIT re-requests, so the conversion stays outstanding.
  always_comb begin
    state_next_c = state;
    case (state)
      IDLE:    if (tick_c) state_next_c = WAIT;
      WAIT:    if (adc_valid && !tick_c) state_next_c = IDLE;
      default: state_next_c = IDLE;
    endcase
  end

  always_comb begin
    req_c  = 1'b0;
    push_c = 1'b0;
    miss_c = 1'b0;
    case (state)
      IDLE: req_c = tick_c;
      WAIT: begin
        req_c  = tick_c;
        push_c = adc_valid;
        miss_c = tick_c && !adc_valid;
      end
      default: ;
    endcase
  end

`ifdef ADC_OFFSET_BINARY_EN
  assign code_c = adc_data ^ {1'b1, {(adc_width-1){1'b0}}};
`else
  assign code_c = adc_data;
`endif
  assign aligned_c = inout_width'(code_c) << SHIFT;

  assign pop_c         = m_axis_tvalid && m_axis_tready;
  assign m_axis_tvalid = !fifo_empty;

  // Request strobe and sticky flags; a same-cycle set beats clear_flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_req <= 1'b0;
      overflow   <= 1'b0;
      missed     <= 1'b0;
    end else begin
      sample_req <= req_c;
      overflow   <= (push_c && fifo_full && !pop_c) || (overflow && !clear_flags);
      missed     <= miss_c || (missed && !clear_flags);
    end
  end

  ecg_sync_fifo #(
    .width      (inout_width),
    .addr_width (fifo_addr_width)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_c),
    .din   (aligned_c),
    .pop   (pop_c),
    .dout  (m_axis_tdata),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (fifo_level)
  );

endmodule

// File: tb/tb_ecg_axis_sample_source.sv
// Directed bench for ecg_axis_sample_source with tick_div=10 and an 8-deep FIFO.
`timescale 1ns/1ps
module tb_ecg_axis_sample_source;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 12;
  localparam int unsigned TD = 10;
  localparam int unsigned FA = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          sample_req;
  logic          adc_valid;
  logic [AW-1:0] adc_data;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [FA:0]   fifo_level;
  logic          overflow;
  logic          missed;
  logic          clear_flags;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  ecg_axis_sample_source #(
    .inout_width     (DW),
    .adc_width       (AW),
    .tick_div        (TD),
    .fifo_addr_width (FA)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .sample_req    (sample_req),
    .adc_valid     (adc_valid),
    .adc_data      (adc_data),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .fifo_level    (fifo_level),
    .overflow      (overflow),
    .missed        (missed),
    .clear_flags   (clear_flags)
  );

  typedef struct {
    logic [AW-1:0] code;
    logic [DW-1:0] exp;
  } vec_t;
  vec_t vecs[5];

  // ADC front-end model: answers each request after model_delay cycles.
  bit            model_on  = 1'b0;
  bit            model_inc = 1'b0;
  int            model_delay = 3;
  int            pend = 0;
  logic [AW-1:0] model_code = '0;

  initial forever begin
    @(negedge clk);
    if (model_on) begin
      adc_valid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          adc_valid = 1'b1;
          adc_data  = model_code;
          if (model_inc) model_code++;
        end
      end
      if (sample_req && pend == 0) pend = model_delay;
    end else begin
      pend = 0;
    end
  end

  // Scoreboard of accepted samples while the sink is stalled.
  logic [AW-1:0] sb[$];
  bit track   = 1'b0;
  bit exp_ovf = 1'b0;
  always @(posedge clk) begin
    if (track && adc_valid) begin
      if (sb.size() < 8) sb.push_back(adc_data);
      else exp_ovf = 1'b1;
    end
  end

  function automatic logic [DW-1:0] exp_align(input logic [AW-1:0] c);
    logic [AW-1:0] v;
    v = c;
`ifdef ADC_OFFSET_BINARY_EN
    v[AW-1] = ~v[AW-1];
`endif
    return {v, 4'h0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out waiting", name);
  endtask

  // Returns at the negedge where sample_req is seen high.
  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sample_req) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("sample_req");
  endtask

  // Returns at the negedge following the edge that captured adc_valid.
  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      if (adc_valid) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
    if (!ok) timeout("adc_valid");
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"},    32'(sample_req),    0);
    check({tag, "_tvalid"}, 32'(m_axis_tvalid), 0);
    check({tag, "_tdata"},  32'(m_axis_tdata),  0);
    check({tag, "_level"},  32'(fifo_level),    0);
    check({tag, "_ovf"},    32'(overflow),      0);
    check({tag, "_missed"}, 32'(missed),        0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int t0;
    rst_n = 1'b0; enable = 1'b0; adc_valid = 1'b0; adc_data = '0;
    m_axis_tready = 1'b0; clear_flags = 1'b0;
`ifdef ADC_OFFSET_BINARY_EN
    vecs[0] = '{12'h800, 16'h0000};
    vecs[1] = '{12'hFFF, 16'h7FF0};
    vecs[2] = '{12'h000, 16'h8000};
    vecs[3] = '{12'h7FF, 16'hFFF0};
    vecs[4] = '{12'h123, 16'h9230};
`else
    vecs[0] = '{12'h123, 16'h1230};
    vecs[1] = '{12'h800, 16'h8000};
    vecs[2] = '{12'h7FF, 16'h7FF0};
    vecs[3] = '{12'hFFF, 16'hFFF0};
    vecs[4] = '{12'h000, 16'h0000};
`endif

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Basic stream: request period, one-cycle strobe, one-cycle latency.
    model_code = 12'h123; model_on = 1'b1; m_axis_tready = 1'b1; enable = 1'b1;
    wait_req(ok); t0 = cyc;
    @(negedge clk);
    check("req_width", 32'(sample_req), 0);
    wait_valid(ok);
    check("lat_tvalid", 32'(m_axis_tvalid), 1);
    check("lat_tdata", 32'(m_axis_tdata), 32'(exp_align(12'h123)));
    @(negedge clk);
    check("empty_tvalid", 32'(m_axis_tvalid), 0);
    check("empty_hold_tdata", 32'(m_axis_tdata), 32'(exp_align(12'h123)));
    wait_req(ok);
    check("req_period", 32'(cyc - t0), TD);

    // Alignment table.
    for (int i = 0; i < 5; i++) begin
      model_code = vecs[i].code;
      wait_valid(ok);
      check("align_tvalid", 32'(m_axis_tvalid), 1);
      check("align_tdata", 32'(m_axis_tdata), 32'(vecs[i].exp));
    end

    // Stalled sink: fill, drop, then drain in order.
    @(negedge clk);
    m_axis_tready = 1'b0; model_inc = 1'b1; model_code = 12'h010; track = 1'b1;
    repeat (120) @(negedge clk);
    enable = 1'b0;
    repeat (12) @(negedge clk);
    track = 1'b0; model_on = 1'b0; adc_valid = 1'b0;
    check("full_level", 32'(fifo_level), 8);
    check("overflow_set", 32'(overflow), 32'(exp_ovf));
    for (int i = 0; i < 8; i++) begin
      check("drain_tvalid", 32'(m_axis_tvalid), 1);
      check("drain_tdata", 32'(m_axis_tdata), 32'(exp_align(sb[i])));
      m_axis_tready = 1'b1;
      @(negedge clk);
    end
    check("drained_tvalid", 32'(m_axis_tvalid), 0);
    check("drained_level", 32'(fifo_level), 0);
    check("overflow_sticky", 32'(overflow), 1);
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
    check("overflow_clear", 32'(overflow), 0);

    // Unanswered request -> missed, then tick coinciding with adc_valid.
    m_axis_tready = 1'b0; enable = 1'b1;
    wait_req(ok);
    check("missed_before", 32'(missed), 0);
    wait_req(ok);
    check("missed_set", 32'(missed), 1);
    check("missed_no_push", 32'(fifo_level), 0);
    @(negedge clk);
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
    check("missed_clear", 32'(missed), 0);
    repeat (7) @(negedge clk);
    adc_valid = 1'b1; adc_data = 12'h456;
    @(negedge clk);
    adc_valid = 1'b0;
    check("coinc_req", 32'(sample_req), 1);
    check("coinc_missed", 32'(missed), 0);
    check("coinc_level", 32'(fifo_level), 1);
    check("coinc_tdata", 32'(m_axis_tdata), 32'(exp_align(12'h456)));
    adc_valid = 1'b1; adc_data = 12'h321;
    @(negedge clk);
    adc_valid = 1'b0; enable = 1'b0;
    check("answer_level", 32'(fifo_level), 2);
    @(negedge clk);
    adc_valid = 1'b1; adc_data = 12'h555;
    @(negedge clk);
    adc_valid = 1'b0;
    @(negedge clk);
    check("idle_ignore_level", 32'(fifo_level), 2);
    check("idle_ignore_missed", 32'(missed), 0);
    m_axis_tready = 1'b1;
    repeat (3) @(negedge clk);
    m_axis_tready = 1'b0;

    // Full FIFO with simultaneous push and pop.
    model_on = 1'b1; model_code = 12'h0A0; enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (fifo_level == 4'd8) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("fill_to_8");
    enable = 1'b0;
    repeat (12) @(negedge clk);
    model_on = 1'b0; adc_valid = 1'b0;
    check("fill_head", 32'(m_axis_tdata), 32'(exp_align(12'h0A0)));
    enable = 1'b1;
    wait_req(ok);
    enable = 1'b0;
    adc_valid = 1'b1; adc_data = 12'h0B0; m_axis_tready = 1'b1;
    @(negedge clk);
    adc_valid = 1'b0; m_axis_tready = 1'b0;
    check("pushpop_level", 32'(fifo_level), 8);
    check("pushpop_ovf", 32'(overflow), 0);
    check("pushpop_head", 32'(m_axis_tdata), 32'(exp_align(12'h0A1)));

    // Reset in WAIT with five entries queued.
    m_axis_tready = 1'b1;
    repeat (3) @(negedge clk);
    m_axis_tready = 1'b0;
    check("pre_reset_level", 32'(fifo_level), 5);
    enable = 1'b1;
    wait_req(ok);
    enable = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    adc_valid = 1'b1; adc_data = 12'h7FF;
    @(negedge clk);
    adc_valid = 1'b0;
    @(negedge clk);
    check("late_valid_level", 32'(fifo_level), 0);
    check("late_valid_tvalid", 32'(m_axis_tvalid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
